mips_mem_arbiter: RTL

Sequences and shares the single off-processor memory port between two requesters: the MIPS processor (port 0, "cpu") and a debug/program-loader master (port 1, "dbg").
- Accepts one transaction at a time and drives the memory strobes for one cycle.
- Waits a fixed memory latency, then returns read data with a one-cycle ack pulse.
- Sits between mips_processor (addr/memread/memwrite/writedata/memdata) and the memory.

---
 rtl/mips_mem_arb_pkg.sv | 17 +
 rtl/mips_mem_arb_select.sv | 38 +++
 rtl/mips_mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_arb_pkg.sv
// Shared types and constants for the MIPS memory-port arbiter.
package mips_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_DBG    = 1'b1;
  localparam int   MAX_MEM_LAT = 15;
  // Counter wide enough for MAX_MEM_LAT-1.
  localparam int   CNT_W       = 4;

endpackage

// File: rtl/mips_mem_arb_select.sv
// Requester selection for the memory-port arbiter.
// Macro MIPS_MEM_ARB_RR_EN: round-robin with a 1-bit priority pointer;
// otherwise fixed priority, dbg over cpu, and no pointer flop.
module mips_mem_arb_select
  import mips_mem_arb_pkg::*;
(
`ifdef MIPS_MEM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
  input  logic i_accept,
`endif
  input  logic i_cpu_req,
  input  logic i_dbg_req,
  output logic o_valid,
  output logic o_winner
);

  assign o_valid = i_cpu_req | i_dbg_req;

`ifdef MIPS_MEM_ARB_RR_EN
  logic r_ptr;

  // Pointer hands priority to the loser of every accepted transaction.
  always_ff @(posedge clk) begin
    if (reset)         r_ptr <= PORT_CPU;
    else if (i_accept) r_ptr <= ~o_winner;
  end

  // Pointer only breaks ties; a sole requester always wins.
  always_comb begin
    o_winner = i_dbg_req ? PORT_DBG : PORT_CPU;
    if (i_cpu_req && i_dbg_req) o_winner = r_ptr;
  end
`else
  assign o_winner = i_dbg_req ? PORT_DBG : PORT_CPU;
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one fixed-latency memory port between the MIPS cpu and a debug/loader
// master: one transaction at a time, one-cycle strobe, one-cycle ack.
// Macro MIPS_MEM_ARB_RR_EN selects round-robin arbitration (default: dbg wins).
module mips_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant
);

  if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : g_bad_lat
    $error("mips_mem_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  arb_state_t      r_state, w_state_nxt;
  logic            r_we, r_grant;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata, r_cpu_rdata, r_dbg_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic            w_valid, w_winner, w_accept, w_cnt_zero;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  mips_mem_arb_select u_select (
`ifdef MIPS_MEM_ARB_RR_EN
    .clk      (clk),
    .reset    (reset),
    .i_accept (w_accept),
`endif
    .i_cpu_req(cpu_req),
    .i_dbg_req(dbg_req),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  assign w_sel_we    = w_winner ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_winner ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_winner ? dbg_wdata : cpu_wdata;
  assign w_cnt_zero  = (r_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus strobe/ack decode; requests only matter in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    cpu_ack     = 1'b0;
    dbg_ack     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_read    = ~r_we;
        mem_write   = r_we;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_cnt_zero) w_state_nxt = DONE;
      end
      DONE: begin
        cpu_ack     = (r_grant == PORT_CPU);
        dbg_ack     = (r_grant == PORT_DBG);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transaction latch, latency counter and per-port read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_grant     <= PORT_CPU;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= w_sel_we;
        r_grant <= w_winner;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == ISSUE) r_cnt <= LAT_M1;
      if (r_state == WAIT) begin
        if (!w_cnt_zero) begin
          r_cnt <= r_cnt - 1'b1;
        end else if (!r_we) begin
          if (r_grant == PORT_DBG) r_dbg_rdata <= mem_rdata;
          else                     r_cpu_rdata <= mem_rdata;
        end
      end
    end
  end

  // Address/data/grant come straight from the latch so they hold outside ISSUE.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign grant     = r_grant;
  assign busy      = (r_state != IDLE);
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;

endmodule
